// File: rtl/types_pkg.sv
// Shared types for the pipeline hazard controller: bus widths, forwarding select, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package types_pkg;

    localparam int ADDR_BUS = 5;
    localparam int DATA_BUS = 32;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel;

    typedef logic [1:0] hz_state;

    localparam hz_state RUN      = 2'b00;
    localparam hz_state MEM_WAIT = 2'b01;
    localparam hz_state ERROR    = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Picks the ALU operand source for one E-stage source register; M-stage result wins over W.
// Latency: purely combinational.
// Backpressure: none.
module fwd_select
    import types_pkg::*;
(
    input  logic                RegWriteM_i,
    input  logic [ADDR_BUS-1:0] RdM_i,
    input  logic                RegWriteW_i,
    input  logic [ADDR_BUS-1:0] RdW_i,
    input  logic [ADDR_BUS-1:0] RsE_i,
    output fwd_sel              Fwd_o
);

    always_comb begin
        Fwd_o = FWD_NONE;
        if (RegWriteM_i && (RdM_i != '0) && (RdM_i == RsE_i)) begin
            Fwd_o = FWD_MEM;
        end else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == RsE_i)) begin
            Fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit: forwarding, load-use bubbles, branch flushes, memory-wait stalls with timeout.
// Latency: stall/flush/forward outputs are combinational; FSM and counters update on negedge clk.
// Backpressure: MemBusyM_i freezes F/D/E/M and bubbles W until it drops or the timeout latches ERROR.
module pipeline_hazard_ctrl
    import types_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_BUS-1:0] Rs1D_i,
    input  logic [ADDR_BUS-1:0] Rs2D_i,
    input  logic [ADDR_BUS-1:0] Rs1E_i,
    input  logic [ADDR_BUS-1:0] Rs2E_i,
    input  logic [ADDR_BUS-1:0] RdE_i,
    input  logic [ADDR_BUS-1:0] RdM_i,
    input  logic [ADDR_BUS-1:0] RdW_i,
    input  logic                RegWriteE_i,
    input  logic                RegWriteM_i,
    input  logic                RegWriteW_i,
    input  logic                ResultSrcE_i,
    input  logic                PCSrcE_i,
    input  logic                MemBusyM_i,
    output logic                StallF_o,
    output logic                StallD_o,
    output logic                StallE_o,
    output logic                StallM_o,
    output logic                FlushD_o,
    output logic                FlushE_o,
    output logic                FlushW_o,
    output fwd_sel              ForwardAE_o,
    output fwd_sel              ForwardBE_o,
    output logic                ErrTimeout_o,
    output logic [DATA_BUS-1:0] StallCount_o
);

    localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    hz_state        state;
    logic [WCW-1:0] waitCnt;
    logic [WCW:0]   waitNext;
    logic           lwStall;
    logic           memHold;
    fwd_sel         fwdA;
    fwd_sel         fwdB;

    fwd_select u_fwd_a (
        .RegWriteM_i (RegWriteM_i),
        .RdM_i       (RdM_i),
        .RegWriteW_i (RegWriteW_i),
        .RdW_i       (RdW_i),
        .RsE_i       (Rs1E_i),
        .Fwd_o       (fwdA)
    );

    fwd_select u_fwd_b (
        .RegWriteM_i (RegWriteM_i),
        .RdM_i       (RdM_i),
        .RegWriteW_i (RegWriteW_i),
        .RdW_i       (RdW_i),
        .RsE_i       (Rs2E_i),
        .Fwd_o       (fwdB)
    );

    assign ForwardAE_o = rst_n ? fwdA : FWD_NONE;
    assign ForwardBE_o = rst_n ? fwdB : FWD_NONE;

    assign lwStall = ResultSrcE_i && RegWriteE_i && (RdE_i != '0) &&
                     ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

    // A busy memory outranks branches and load-use; in MEM_WAIT a ready memory
    // drops straight through to the RUN priorities within the same cycle.
    assign memHold = (state == ERROR) || MemBusyM_i;

    always_comb begin
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        StallE_o = 1'b0;
        StallM_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        FlushW_o = 1'b0;
        if (!rst_n) begin
            StallF_o = 1'b0;
        end else if (memHold) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
        end else if (PCSrcE_i) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
        end else if (lwStall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
        end
    end

    assign waitNext = (WCW+1)'(waitCnt) + (WCW+1)'(1);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            waitCnt      <= '0;
            StallCount_o <= '0;
            ErrTimeout_o <= 1'b0;
        end else begin
            if (StallF_o && (StallCount_o != '1)) begin
                StallCount_o <= StallCount_o + DATA_BUS'(1);
            end
            case (state)
                RUN: begin
                    if (MemBusyM_i) begin
                        state   <= MEM_WAIT;
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!MemBusyM_i) begin
                        state <= RUN;
                    end else if (waitNext >= (WCW+1)'(MEM_TIMEOUT)) begin
                        state        <= ERROR;
                        ErrTimeout_o <= 1'b1;
                    end else begin
                        waitCnt <= waitNext[WCW-1:0];
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a cycle-level reference model and literal spot checks.
module tb_pipeline_hazard_ctrl;
    import types_pkg::*;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ADDR_BUS-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
    logic [ADDR_BUS-1:0] RdE = '0, RdM = '0, RdW = '0;
    logic RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic ResultSrcE = 1'b0, PCSrcE = 1'b0, MemBusyM = 1'b0;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ErrTimeout;
    fwd_sel ForwardAE, ForwardBE;
    logic [DATA_BUS-1:0] StallCount;

    int tests = 0;
    int fails = 0;

    // reference model state
    int          consecBusy = 0;
    bit          mErr = 1'b0;
    logic [31:0] mCount = '0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
        .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
        .RegWriteE_i(RegWriteE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
        .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .MemBusyM_i(MemBusyM),
        .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
        .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW),
        .ForwardAE_o(ForwardAE), .ForwardBE_o(ForwardBE),
        .ErrTimeout_o(ErrTimeout), .StallCount_o(StallCount)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [6:0] expCtl();
        logic lw;
        lw = ResultSrcE && RegWriteE && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
        if (!rst_n)                 return 7'b0000000;
        else if (mErr || MemBusyM)  return 7'b1111001;
        else if (PCSrcE)            return 7'b0000110;
        else if (lw)                return 7'b1100010;
        else                        return 7'b0000000;
    endfunction

    function automatic fwd_sel expFwd(input logic [ADDR_BUS-1:0] rs);
        if (!rst_n)                                 return FWD_NONE;
        if (RegWriteM && RdM != 0 && RdM == rs)     return FWD_MEM;
        if (RegWriteW && RdW != 0 && RdW == rs)     return FWD_WB;
        return FWD_NONE;
    endfunction

    // Timeout expressed as a run length: one RUN busy cycle plus TO waiting cycles.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consecBusy = 0;
            mErr = 1'b0;
            mCount = '0;
        end else begin
            if (expCtl() >= 7'b1000000 && mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
            consecBusy = MemBusyM ? consecBusy + 1 : 0;
            if (consecBusy >= TO + 1) mErr = 1'b1;
        end
    end

    always @(posedge clk) begin
        check("ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, expCtl());
        check("fwdA", ForwardAE, expFwd(Rs1E));
        check("fwdB", ForwardBE, expFwd(Rs2E));
        check("err", ErrTimeout, mErr);
        check("count", StallCount, mCount);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clearIn();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        ResultSrcE = 0; PCSrcE = 0; MemBusyM = 0;
    endtask

    initial begin
        int nStall;
        #2;
        check("rst_ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 7'b0);
        check("rst_count", StallCount, 32'd0);
        check("rst_err", ErrTimeout, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // forwarding priority
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 check("fwd_mem", ForwardAE, FWD_MEM);
        RdM = 0;
        #1 check("fwd_wb", ForwardAE, FWD_WB);
        Rs1E = 0;
        #1 check("fwd_none", ForwardAE, FWD_NONE);
        Rs2E = 7; RdM = 7; RdW = 7;
        #1 check("fwdB_mem", ForwardBE, FWD_MEM);
        RegWriteM = 0;
        #1 check("fwdB_wb", ForwardBE, FWD_WB);
        cyc(); clearIn(); cyc();

        // load-use bubble
        ResultSrcE = 1; RegWriteE = 1; RdE = 3; Rs2D = 3;
        #1 check("lw_ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 7'b1100010);
        cyc(); clearIn();
        #1 check("lw_count", StallCount, 32'd1);
        // x0 destination never stalls
        ResultSrcE = 1; RegWriteE = 1; RdE = 0; Rs1D = 0;
        #1 check("lw_x0", {StallF, StallD, FlushE}, 3'b000);
        cyc(); clearIn();

        // branch beats load-use
        ResultSrcE = 1; RegWriteE = 1; RdE = 3; Rs2D = 3; PCSrcE = 1;
        #1 check("br_ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 7'b0000110);
        cyc(); clearIn();
        #1 check("br_count", StallCount, 32'd1);
        cyc();

        // four-cycle memory wait
        nStall = 0;
        for (int i = 0; i < 6; i++) begin
            MemBusyM = (i < 4);
            @(posedge clk);
            if (StallF) nStall++;
            cyc();
        end
        check("mw_stall_cycles", nStall, 4);
        check("mw_count", StallCount, 32'd5);
        check("mw_err", ErrTimeout, 1'b0);
        check("mw_state", dut.state, RUN);

        // timeout: 16 consecutive busy cycles reach ERROR
        for (int i = 1; i <= 20; i++) begin
            MemBusyM = 1;
            cyc();
            if (i == 15) begin
                check("to_err_before", ErrTimeout, 1'b0);
                check("to_count15", StallCount, 32'd20);
            end
            if (i == 16) begin
                check("to_err_at", ErrTimeout, 1'b1);
                check("to_count16", StallCount, 32'd21);
            end
        end
        MemBusyM = 0;
        #1 check("err_hold", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 7'b1111001);
        Rs1E = 5; RdM = 5; RegWriteM = 1;
        #1 check("err_fwd", ForwardAE, FWD_MEM);
        check("err_count", StallCount, 32'd25);

        // async reset mid-cycle out of ERROR
        MemBusyM = 1;
        rst_n = 1'b0;
        #1;
        check("arst_ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 7'b0);
        check("arst_fwd", ForwardAE, FWD_NONE);
        check("arst_err", ErrTimeout, 1'b0);
        check("arst_count", StallCount, 32'd0);
        check("arst_state", dut.state, RUN);
        cyc();
        rst_n = 1'b1;
        #1 check("post_rst_hold", {StallF, FlushW, ErrTimeout}, 3'b110);
        cyc();
        clearIn();
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive MEM_WAIT cycles before the error state.
REQ-002 SHALL have port clk  input  1  pipeline clock; state updates on the negedge, aligned with the pipeline registers.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports Rs1D_i, Rs2D_i  input  ADDR_BUS  source registers of the decode-stage instruction.
REQ-005 SHALL have ports Rs1E_i, Rs2E_i  input  ADDR_BUS  source registers of the execute-stage instruction.
REQ-006 SHALL have ports RdE_i, RdM_i, RdW_i  input  ADDR_BUS  destination registers in E/M/W.
REQ-007 SHALL have ports RegWriteE_i, RegWriteM_i, RegWriteW_i  input  1  register-write enables in E/M/W.
REQ-008 SHALL have port ResultSrcE_i  input  1  high when the E instruction is a load.
REQ-009 SHALL have port PCSrcE_i  input  1  branch or jump taken, resolved in E.
REQ-010 SHALL have port MemBusyM_i  input  1  data memory not ready for the M-stage access.
REQ-011 SHALL have ports StallF_o, StallD_o, StallE_o, StallM_o  output  1  hold the PC or stage register.
REQ-012 SHALL have ports FlushD_o, FlushE_o, FlushW_o  output  1  insert a bubble into the stage register.
REQ-013 SHALL have ports ForwardAE_o, ForwardBE_o  output  fwd_sel  ALU operand source select.
REQ-014 SHALL have port ErrTimeout_o  output  1  memory-wait timeout flag; sticky until reset.
REQ-015 SHALL have port StallCount_o  output  DATA_BUS  count of stalled cycles, for performance measurement.

Function
REQ-016 ForwardAE_o SHALL select FWD_MEM if RegWriteM_i and RdM_i!=0 and RdM_i==Rs1E_i; else FWD_WB if RegWriteW_i and RdW_i!=0 and RdW_i==Rs1E_i; else FWD_NONE. This output is combinational.
REQ-017 ForwardBE_o SHALL follow the same rule as REQ-016 using Rs2E_i; M-stage forwarding has priority over W-stage when both match.
REQ-018 Load-use hazard lwStall SHALL be ResultSrcE_i and RegWriteE_i and RdE_i!=0 and (RdE_i==Rs1D_i or RdE_i==Rs2D_i).
REQ-019 FSM SHALL have the states RUN, MEM_WAIT and ERROR (type hz_state).
REQ-020 In RUN with MemBusyM_i=1: StallF/D/E/M=1 and FlushW=1 in the same cycle (Mealy); FSM goes to MEM_WAIT at the next negedge.
REQ-021 In RUN with MemBusyM_i=0 and PCSrcE_i=1: FlushD=1 and FlushE=1; all stalls=0, even if lwStall=1.
REQ-022 In RUN with MemBusyM_i=0, PCSrcE_i=0 and lwStall=1: StallF=1, StallD=1, FlushE=1; exactly one bubble is inserted.
REQ-023 In MEM_WAIT: StallF/D/E/M=1 and FlushW=1 while MemBusyM_i=1; PCSrcE_i and lwStall are ignored.
REQ-024 In MEM_WAIT with MemBusyM_i=0: stalls release in the same cycle, RUN rules apply combinationally, and the FSM returns to RUN at the next negedge.
REQ-025 Wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle with MemBusyM_i=1.
REQ-026 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to ERROR.
REQ-027 ERROR: ErrTimeout_o=1, StallF/D/E/M=1, FlushW=1, forwarding unchanged; ERROR is exited only by reset.
REQ-028 StallCount_o SHALL increment at each negedge where StallF_o=1 and saturate at 0xFFFFFFFF (no wrap).
REQ-029 All outputs not asserted by REQ-020 to REQ-027 SHALL be 0.

Reset
REQ-030 rst_n=0 SHALL immediately force: state RUN, wait counter 0, StallCount_o 0, ErrTimeout_o 0.
REQ-031 While rst_n=0, all stall and flush outputs SHALL be 0, and ForwardAE_o/ForwardBE_o SHALL be FWD_NONE.
REQ-032 Reset asserted mid-MEM_WAIT or in ERROR SHALL abort to RUN with no residual stall.

Structure
REQ-033 types_pkg SHALL hold fwd_sel (FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10) and hz_state.
REQ-034 One sub-module fwd_select SHALL implement the REQ-016 compare and be instantiated twice (operands A and B).
REQ-035 The block SHALL contain no storage besides the FSM state, the wait counter, StallCount_o and ErrTimeout_o.

Verification
REQ-036 Forwarding: Rs1E=5, RdM=5/RegWriteM=1, RdW=5/RegWriteW=1 -> ForwardAE=FWD_MEM; with RdM=0 -> FWD_WB; with Rs1E=0 and RdM=0 -> FWD_NONE.
REQ-037 Load-use: ResultSrcE=1, RegWriteE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle; StallCount_o increments by 1.
REQ-038 Simultaneous events: REQ-037 stimulus plus PCSrcE=1 -> FlushD=FlushE=1, StallF=0, StallCount_o unchanged.
REQ-039 Memory wait: MemBusyM=1 for 4 cycles then 0 -> stalls high exactly 4 cycles, FSM back in RUN, StallCount_o=4, ErrTimeout_o=0.
REQ-040 Timeout and reset: MemBusyM=1 held for 20 cycles with MEM_TIMEOUT=15 -> ErrTimeout_o=1 and stalls held; pulse rst_n low mid-hold -> all outputs 0 immediately and state RUN.
